note_scheduler: RTL

//  Sequences detected pitches into the on-screen score. Inputs: per-window note codes from the

---
 rtl/score_pkg.sv | 21 ++
 rtl/duration_quantizer.sv | 34 +++
 rtl/note_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared score types: duration encoding, slot entry layout and the silence code.
// Also used by musicscore when it decodes slot reads.
package score_pkg;

    localparam int         RUN_W        = 5;
    localparam logic [7:0] NOTE_SILENCE = 8'h00;

    typedef enum logic [3:0] {
        DUR_NONE    = 4'b0000,
        DUR_EIGHTH  = 4'b0001,
        DUR_QUARTER = 4'b0010,
        DUR_HALF    = 4'b0100,
        DUR_WHOLE   = 4'b1000
    } dur_t;

    typedef struct packed {
        logic [7:0] note;
        dur_t       dur;
    } slot_t;

endpackage

// File: rtl/duration_quantizer.sv
// Maps a run length (in detector windows) to a note duration.
// emit_ok is low for runs too short to draw.
module duration_quantizer
    import score_pkg::*;
#(
    parameter logic [RUN_W-1:0] EIGHTH_MIN  = 5'd2,
    parameter logic [RUN_W-1:0] QUARTER_MIN = 5'd4,
    parameter logic [RUN_W-1:0] HALF_MIN    = 5'd8,
    parameter logic [RUN_W-1:0] WHOLE_MIN   = 5'd16
) (
    input  logic [RUN_W-1:0] run_cnt,
    output dur_t             dur,
    output logic             emit_ok
);

    always_comb begin
        dur     = DUR_NONE;
        emit_ok = 1'b0;
        if (run_cnt >= WHOLE_MIN) begin
            dur     = DUR_WHOLE;
            emit_ok = 1'b1;
        end else if (run_cnt >= HALF_MIN) begin
            dur     = DUR_HALF;
            emit_ok = 1'b1;
        end else if (run_cnt >= QUARTER_MIN) begin
            dur     = DUR_QUARTER;
            emit_ok = 1'b1;
        end else if (run_cnt >= EIGHTH_MIN) begin
            dur     = DUR_EIGHTH;
            emit_ok = 1'b1;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Turns per-window pitch codes into quantised score entries committed during vblank.
// Optional build macro REST_DETECT_EN: silence runs are tracked and emitted as rests.
module note_scheduler
    import score_pkg::*;
#(
    parameter int               NUM_SLOTS   = 16,
    parameter int               SLOT_W      = $clog2(NUM_SLOTS),
    parameter logic [RUN_W-1:0] EIGHTH_MIN  = 5'd2,
    parameter logic [RUN_W-1:0] QUARTER_MIN = 5'd4,
    parameter logic [RUN_W-1:0] HALF_MIN    = 5'd8,
    parameter logic [RUN_W-1:0] WHOLE_MIN   = 5'd16,
    parameter logic [RUN_W-1:0] RUN_MAX     = 5'd22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [7:0]        note,
    input  logic              vblank,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [7:0]        rd_note,
    output logic [3:0]        rd_dur,
    output logic              rd_valid,
    output logic [SLOT_W:0]   slot_count,
    output logic              page_clear,
    output logic              overflow
);

`ifdef REST_DETECT_EN
    localparam bit REST_EN = 1'b1;
`else
    localparam bit REST_EN = 1'b0;
`endif

    localparam logic [SLOT_W:0] FULL_COUNT = (SLOT_W+1)'(NUM_SLOTS);

    typedef enum logic {ST_IDLE, ST_TRACK} state_t;

    state_t            state_reg, state_next;
    logic [7:0]        cur_note_reg, cur_note_next;
    logic [RUN_W-1:0]  run_cnt_reg, run_cnt_next;
    logic              emit_valid;
    slot_t             emit_entry;
    dur_t              q_dur;
    logic              q_ok;
    logic              track_ok;

    slot_t             pending_reg;
    logic              pending_valid_reg;
    logic              overflow_reg;
    logic              page_clear_reg;
    logic [SLOT_W-1:0] wr_ptr_reg;
    logic [SLOT_W:0]   slot_count_reg;
    logic [NUM_SLOTS-1:0] valid_reg;
    slot_t             rd_entry_reg;
    logic              rd_valid_reg;

    logic              commit;
    logic              page_full;
    logic [SLOT_W-1:0] wr_addr;

    duration_quantizer #(
        .EIGHTH_MIN (EIGHTH_MIN),
        .QUARTER_MIN(QUARTER_MIN),
        .HALF_MIN   (HALF_MIN),
        .WHOLE_MIN  (WHOLE_MIN)
    ) u_quant (
        .run_cnt(run_cnt_reg),
        .dur    (q_dur),
        .emit_ok(q_ok)
    );

    // Silence starts a run only when rests are being drawn.
    assign track_ok = (note != NOTE_SILENCE) || REST_EN;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cur_note_reg <= NOTE_SILENCE;
            run_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cur_note_reg <= cur_note_next;
            run_cnt_reg  <= run_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cur_note_next   = cur_note_reg;
        run_cnt_next    = run_cnt_reg;
        emit_valid      = 1'b0;
        emit_entry.note = cur_note_reg;
        emit_entry.dur  = DUR_NONE;
        if (sample_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (track_ok) begin
                        state_next    = ST_TRACK;
                        cur_note_next = note;
                        run_cnt_next  = 5'd1;
                    end
                end
                ST_TRACK: begin
                    if (note == cur_note_reg) begin
                        // A very long note is split into tied wholes.
                        if (run_cnt_reg + 5'd1 == RUN_MAX) begin
                            emit_valid     = 1'b1;
                            emit_entry.dur = DUR_WHOLE;
                            run_cnt_next   = '0;
                        end else if (run_cnt_reg != RUN_MAX) begin
                            run_cnt_next = run_cnt_reg + 5'd1;
                        end
                    end else begin
                        emit_valid     = q_ok;
                        emit_entry.dur = q_dur;
                        if (track_ok) begin
                            cur_note_next = note;
                            run_cnt_next  = 5'd1;
                        end else begin
                            state_next   = ST_IDLE;
                            run_cnt_next = '0;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign commit    = vblank && pending_valid_reg;
    assign page_full = (slot_count_reg == FULL_COUNT);
    assign wr_addr   = page_full ? '0 : wr_ptr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            overflow_reg      <= 1'b0;
            page_clear_reg    <= 1'b0;
            wr_ptr_reg        <= '0;
            slot_count_reg    <= '0;
        end else begin
            page_clear_reg <= commit && page_full;
            // A committing entry frees the pending slot in the same cycle.
            if (emit_valid) begin
                if (!pending_valid_reg || commit) begin
                    pending_reg       <= emit_entry;
                    pending_valid_reg <= 1'b1;
                end else begin
                    overflow_reg <= 1'b1;
                end
            end else if (commit) begin
                pending_valid_reg <= 1'b0;
            end
            if (commit) begin
                if (page_full) begin
                    wr_ptr_reg     <= SLOT_W'(1);
                    slot_count_reg <= (SLOT_W+1)'(1);
                end else begin
                    wr_ptr_reg     <= wr_ptr_reg + SLOT_W'(1);
                    slot_count_reg <= slot_count_reg + (SLOT_W+1)'(1);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_valid
            logic valid_bit_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_bit_reg <= 1'b0;
                end else if (commit) begin
                    if (page_full) begin
                        valid_bit_reg <= (gi == 0);
                    end else if (wr_addr == SLOT_W'(gi)) begin
                        valid_bit_reg <= 1'b1;
                    end
                end
            end
            assign valid_reg[gi] = valid_bit_reg;
        end
    endgenerate

    slot_t slot_mem [NUM_SLOTS];

    always_ff @(posedge clk) begin
        if (commit) begin
            slot_mem[wr_addr] <= pending_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_entry_reg <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_entry_reg <= slot_mem[rd_slot];
            rd_valid_reg <= valid_reg[rd_slot];
        end
    end

    assign rd_note    = rd_entry_reg.note;
    assign rd_dur     = rd_entry_reg.dur;
    assign rd_valid   = rd_valid_reg;
    assign slot_count = slot_count_reg;
    assign page_clear = page_clear_reg;
    assign overflow   = overflow_reg;

endmodule
